// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register of the pipelined RV32I CPU.
//
// Purpose:
//   Captures PC, PC+4, instruction word and halt flag from fetch. Slices the
//   RV32I register fields out of the held instruction. Detects a load-use
//   hazard against the load in ID/EX. Stalls fetch and bubbles ID/EX when a
//   hazard is found. Squashes its contents on a taken branch or jump. Counts
//   hazard stall cycles in a saturating counter.
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   pc/pc4/instr/halt_in_id  fetch outputs to capture
//   flush_in_id              taken branch/jump resolved downstream
//   idex_memread_in_id       the instruction in ID/EX is a load
//   idex_rd_in_id            destination register of the ID/EX instruction
//   pc/pc4/instr_out_id      registered copies of the fetch outputs
//   valid_out_id             IF/ID holds a live instruction
//   halt_out_id              a live halt is held (sticky until flush/reset)
//   opcode/rd/rs1/rs2_out_id field slices of instr_out_id
//   stall_out_id             hold the fetch PC
//   bubble_out_id            ID/EX must load a NOP this cycle
//   stall_count_out_id       saturating count of load-use stall cycles
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_in_id,
    input  logic [31:0]      pc4_in_id,
    input  logic [31:0]      instr_in_id,
    input  logic             halt_in_id,
    input  logic             flush_in_id,
    input  logic             idex_memread_in_id,
    input  logic [4:0]       idex_rd_in_id,
    output logic [31:0]      pc_out_id,
    output logic [31:0]      pc4_out_id,
    output logic [31:0]      instr_out_id,
    output logic             valid_out_id,
    output logic             halt_out_id,
    output logic [6:0]       opcode_out_id,
    output logic [4:0]       rd_out_id,
    output logic [4:0]       rs1_out_id,
    output logic [4:0]       rs2_out_id,
    output logic             stall_out_id,
    output logic             bubble_out_id,
    output logic [CNT_W-1:0] stall_count_out_id
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic uses_rs1;
    logic uses_rs2;
    logic haz;

    assign pc_out_id          = pc_q;
    assign pc4_out_id         = pc4_q;
    assign instr_out_id       = instr_q;
    assign valid_out_id       = valid_q;
    assign halt_out_id        = halt_q;
    assign stall_count_out_id = cnt_q;

    // Pure slices. A flushed or reset register holds NOP_INSTR, so the
    // fields read as NOP fields whenever the stage is not valid.
    assign opcode_out_id = instr_q[6:0];
    assign rd_out_id     = instr_q[11:7];
    assign rs1_out_id    = instr_q[19:15];
    assign rs2_out_id    = instr_q[24:20];

    // Only compare a source field the instruction actually reads. Otherwise
    // immediate bits in rs1/rs2 positions (LUI, JAL, I-type) stall for nothing.
    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode_out_id)
            OP_LUI, OP_AUIPC, OP_JAL:   uses_rs1 = 1'b0;
            default:                    uses_rs1 = 1'b1;
        endcase
        case (opcode_out_id)
            OP_BRANCH, OP_STORE, OP_OP: uses_rs2 = 1'b1;
            default:                    uses_rs2 = 1'b0;
        endcase
        haz = valid_q & idex_memread_in_id & (idex_rd_in_id != 5'd0) &
              ((uses_rs1 & (rs1_out_id == idex_rd_in_id)) |
               (uses_rs2 & (rs2_out_id == idex_rd_in_id)));
    end

    // A flush kills the dependent instruction, so there is nothing to stall
    // for. ID/EX still gets a bubble either way.
    assign stall_out_id  = haz & ~flush_in_id;
    assign bubble_out_id = haz | flush_in_id;

    // Priority: flush > stall > halt hold > load.
    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        if (flush_in_id) begin
            pc_d    = 32'd0;
            pc4_d   = 32'd0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            halt_d  = 1'b0;
        end else if (!(stall_out_id || halt_q)) begin
            pc_d    = pc_in_id;
            pc4_d   = pc4_in_id;
            instr_d = instr_in_id;
            valid_d = 1'b1;
            halt_d  = halt_in_id;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_out_id && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= 32'd0;
            pc4_q   <= 32'd0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
